// File: rtl/sb_issue_checker.sv
// Issue-side scoreboard: tracks per-register writeback timing with one-hot
// availability vectors, detects RAW / WAW / writeback-port hazards for
// in-order issue, and announces the register being written back each cycle.
module sb_issue_checker #(
    parameter int NREG  = 32,
    parameter int DEPTH = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [4:0]      regA,
    input  logic [4:0]      regB,
    input  logic [4:0]      regC,
    input  logic [1:0]      unidade_fun_in,
    input  logic            flush,
    output logic            stall,
    output logic            issue_fire,
    output logic [0:NREG-1] pendente,
    output logic            wb_valid,
    output logic [4:0]      wb_reg
);

    localparam logic [1:0] FU_ALU   = 2'b00;
    localparam logic [1:0] FU_LOAD  = 2'b01;
    localparam logic [1:0] FU_STORE = 2'b10;
    localparam logic [1:0] FU_MUL   = 2'b11;

    // Bit k of vec_q[r] set: register r writes back k cycles from now.
    logic [NREG-1:0][DEPTH-1:0] vec_q;
    logic [NREG-1:0][DEPTH-1:0] vec_d;

    logic [DEPTH-1:0] col_or;      // OR of all vectors: which future cycles own the port
    logic [DEPTH-1:0] load_val;    // one-hot load pattern for the presented unit
    logic             has_dest;    // presented instruction writes a real register
    logic             port_busy;
    logic             raw_a;
    logic             raw_b;
    logic             waw;

    // Latency-encoded load pattern; STORE has no destination.
    always_comb begin
        load_val = '0;
        case (unidade_fun_in)
            FU_ALU:  load_val = DEPTH'(1) << 1;
            FU_LOAD: load_val = DEPTH'(1) << 2;
            FU_MUL:  load_val = DEPTH'(1) << 4;
            default: load_val = '0;
        endcase
    end

    assign has_dest = (unidade_fun_in != FU_STORE) && (regC != 5'd0);

    // Port occupancy per future cycle, plus the writeback announcement.
    always_comb begin
        col_or = '0;
        wb_reg = '0;
        for (int r = 0; r < NREG; r++) begin
            col_or = col_or | vec_q[r];
            if (vec_q[r][0]) begin
                // Only one vector can hold bit 0, so OR-ing indices is exact.
                wb_reg = wb_reg | 5'(r);
            end
        end
    end

    assign wb_valid = col_or[0];

    // Pending view of each register.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            assign pendente[gi] = |vec_q[gi];
        end
    endgenerate

    // Hazard detection; a source in its writeback cycle is bypassed.
    always_comb begin
        raw_a     = (regA != 5'd0) && (vec_q[regA] != '0) && !vec_q[regA][0];
        raw_b     = (regB != 5'd0) && (vec_q[regB] != '0) && !vec_q[regB][0];
        waw       = has_dest && pendente[regC];
        // The new result lands L cycles after the vectors shift, i.e. it
        // collides with whatever currently holds bit L+1. MUL's L+1 is past
        // the vector, so it can never collide.
        port_busy = 1'b0;
        if (has_dest) begin
            case (unidade_fun_in)
                FU_ALU:  port_busy = col_or[2];
                FU_LOAD: port_busy = col_or[3];
                default: port_busy = 1'b0;
            endcase
        end
        stall = issue_valid && (raw_a || raw_b || waw || port_busy);
    end

    assign issue_fire = issue_valid && !stall && !flush;

    // Per-register next state: flush clears, a firing issue loads, else shift.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_next
            if (gi == 0) begin : g_zero
                assign vec_d[gi] = '0;
            end else begin : g_live
                assign vec_d[gi] = flush ? '0 :
                                   (issue_fire && has_dest && (regC == 5'(gi))) ? load_val :
                                   (vec_q[gi] >> 1);
            end
        end
    endgenerate

    // State register; reset overrides flush and issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

endmodule

// File: tb/tb_sb_issue_checker.sv
// Bench for sb_issue_checker: directed scenarios followed by random traffic,
// every cycle compared against an absolute-cycle writeback schedule model.
module tb_sb_issue_checker;

    localparam logic [1:0] ALU   = 2'b00;
    localparam logic [1:0] LOAD  = 2'b01;
    localparam logic [1:0] STORE = 2'b10;
    localparam logic [1:0] MUL   = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  regA, regB, regC;
    logic [1:0]  unidade_fun_in;
    logic        flush;
    logic        stall;
    logic        issue_fire;
    logic [0:31] pendente;
    logic        wb_valid;
    logic [4:0]  wb_reg;

    always #5 clk = ~clk;

    sb_issue_checker #(.NREG(32), .DEPTH(5)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .regA(regA), .regB(regB), .regC(regC),
        .unidade_fun_in(unidade_fun_in), .flush(flush),
        .stall(stall), .issue_fire(issue_fire), .pendente(pendente),
        .wb_valid(wb_valid), .wb_reg(wb_reg)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wbc[32];           // absolute cycle of writeback, -1 when idle
    bit model_ok = 0;

    // Values observed during the last step, for directed checks.
    logic        o_stall, o_fire, o_wbv;
    logic [4:0]  o_wbr;
    logic [0:31] o_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int lat_of(input logic [1:0] fu);
        case (fu)
            ALU:     return 1;
            LOAD:    return 2;
            MUL:     return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit pend_m(input int r);
        return wbc[r] >= cyc;
    endfunction

    function automatic bit raw_m(input logic [4:0] s);
        return (s != 0) && pend_m(int'(s)) && (wbc[s] != cyc);
    endfunction

    // One clock cycle: drive, check combinational outputs at negedge, advance.
    task automatic step(input logic v, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [1:0] fu,
                        input logic fl, input logic rs);
        bit          e_stall, e_fire, e_wbv, dest, port;
        logic [4:0]  e_wbr;
        logic [0:31] e_pend;
        issue_valid = v; regA = a; regB = b; regC = c;
        unidade_fun_in = fu; flush = fl; rst = rs;
        @(negedge clk);
        e_wbv = 0; e_wbr = 0; port = 0;
        dest = (fu != STORE) && (c != 0);
        for (int r = 0; r < 32; r++) begin
            e_pend[r] = pend_m(r);
            if (wbc[r] == cyc) begin
                e_wbv = 1;
                e_wbr = 5'(r);
            end
            if (dest && wbc[r] == cyc + 1 + lat_of(fu)) port = 1;
        end
        e_stall = v && (raw_m(a) || raw_m(b) || (dest && (pend_m(int'(c)) || port)));
        e_fire  = v && !e_stall && !fl;
        o_stall = stall; o_fire = issue_fire; o_wbv = wb_valid;
        o_wbr = wb_reg; o_pend = pendente;
        if (model_ok) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("issue_fire", 32'(issue_fire), 32'(e_fire));
            chk("pendente", 32'(pendente), 32'(e_pend));
            chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
            chk("wb_reg", 32'(wb_reg), 32'(e_wbr));
        end
        @(posedge clk);
        if (rs || fl) begin
            foreach (wbc[r]) wbc[r] = -1;
            if (rs) model_ok = 1;
        end else if (e_fire && dest) begin
            wbc[c] = cyc + 1 + lat_of(fu);
        end
        cyc++;
        $display("cyc=%0d v=%0b a=%0d b=%0d c=%0d fu=%0d fl=%0b rs=%0b stall=%0b fire=%0b wbv=%0b wbr=%0d",
                 cyc - 1, v, a, b, c, fu, fl, rs, o_stall, o_fire, o_wbv, o_wbr);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, ALU, 0, 0);
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [1:0] fu);
        step(1, a, b, c, fu, 0, 0);
    endtask

    initial begin
        foreach (wbc[r]) wbc[r] = -1;
        rst = 1; issue_valid = 0; regA = 0; regB = 0; regC = 0;
        unidade_fun_in = ALU; flush = 0;
        #1;
        // Reset with random inputs, then reset state.
        step($urandom_range(0, 1), 5'($urandom), 5'($urandom), 5'($urandom),
             2'($urandom), 0, 1);
        step(1, 5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom), 0, 0);
        chk("rst_pend", 32'(o_pend), 32'h0);
        chk("rst_wbv", 32'(o_wbv), 32'h0);
        chk("rst_wbr", 32'(o_wbr), 32'h0);
        chk("rst_stall", 32'(o_stall), 32'h0);
        repeat (6) idle();

        // ALU issue to r5.
        issue(0, 0, 5, ALU);  chk("alu_fire", 32'(o_fire), 32'h1);
        idle();               chk("alu_pend_t1", 32'(o_pend[5]), 32'h1);
        idle();               chk("alu_pend_t2", 32'(o_pend[5]), 32'h1);
                              chk("alu_wbv", 32'(o_wbv), 32'h1);
                              chk("alu_wbr", 32'(o_wbr), 32'd5);
        idle();               chk("alu_pend_t3", 32'(o_pend[5]), 32'h0);

        // RAW behind a MUL to r3.
        issue(0, 0, 3, MUL);
        for (int i = 0; i < 4; i++) begin
            issue(3, 0, 4, ALU); chk("raw_stall", 32'(o_stall), 32'h1);
        end
        issue(3, 0, 4, ALU);  chk("raw_fire", 32'(o_fire), 32'h1);
                              chk("raw_wbr", 32'(o_wbr), 32'd3);
        repeat (3) idle();

        // Writeback-port conflict.
        issue(0, 0, 1, LOAD);
        issue(0, 0, 2, ALU);  chk("port_stall", 32'(o_stall), 32'h1);
        issue(0, 0, 2, ALU);  chk("port_fire", 32'(o_fire), 32'h1);
        idle();               chk("port_wb1", 32'(o_wbr), 32'd1);
        idle();               chk("port_wb2", 32'(o_wbr), 32'd2);
        idle();

        // WAW on r7.
        issue(0, 0, 7, ALU);
        issue(0, 0, 7, LOAD); chk("waw_stall1", 32'(o_stall), 32'h1);
        issue(0, 0, 7, LOAD); chk("waw_stall2", 32'(o_stall), 32'h1);
        issue(0, 0, 7, LOAD); chk("waw_fire", 32'(o_fire), 32'h1);
        repeat (4) idle();

        // Destination x0 never tracked.
        issue(0, 0, 0, ALU);  chk("x0_fire", 32'(o_fire), 32'h1);
        for (int i = 0; i < 3; i++) begin
            idle(); chk("x0_wbv", 32'(o_wbv), 32'h0);
                    chk("x0_pend", 32'(o_pend), 32'h0);
        end

        // Flush drops an in-flight MUL.
        issue(0, 0, 9, MUL);
        idle();
        step(0, 0, 0, 0, ALU, 1, 0);
        issue(9, 0, 10, ALU); chk("fl_stall", 32'(o_stall), 32'h0);
                              chk("fl_fire", 32'(o_fire), 32'h1);
                              chk("fl_pend9", 32'(o_pend[9]), 32'h0);
        idle();
        idle();               chk("fl_wbr", 32'(o_wbr), 32'd10);
        repeat (2) idle();

        // Reset mid-operation.
        issue(0, 0, 4, MUL);
        idle();
        step(0, 0, 0, 0, ALU, 0, 1);
        for (int i = 0; i < 4; i++) begin
            idle(); chk("rstmid_wbv", 32'(o_wbv), 32'h0);
        end

        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 2'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
